dmem_bytelane: RTL and testbench



---
 rtl/dmem_bytelane.sv | 169 ++++++++++++++++
 tb/tb_dmem_bytelane.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressed MIPS data memory for the MEM stage.
//   Little-endian, byte/half/word stores, sign- or zero-extended loads,
//   registered read with a one-cycle valid strobe, and an optional
//   zero-fill sweep after reset that replaces preloaded contents.
//
// Parameters:
//   ADDR_W         byte-address width (4..16); DEPTH = 2**(ADDR_W-2) words
//   CLEAR_ON_RESET 1 = zero-fill sweep after reset, 0 = start ready
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   address      byte address
//   writedata    store data, right-justified for byte/half
//   memwr/memrd  store / load request
//   size         00 byte, 01 half, 10/11 word
//   unsigned_ld  1 = zero-extend loads, 0 = sign-extend
//   readData     extended load result, held until the next load
//   rd_valid     readData updated this cycle
//   busy         clear sweep in progress, requests dropped
//   misalign     misaligned-access strobe
//
// Build option:
//   DMEM_ALIGN_CHECK_EN  defined: misaligned half/word accesses are flagged,
//                        stores suppressed, loads return 0.
//                        undefined: low address bits are forced to natural
//                        alignment and misalign stays 0.
//
// state   | meaning
// ST_INIT | zero-fill sweep, one word per cycle, busy high
// ST_IDLE | serving loads and stores

module dmem_bytelane #(
    parameter int ADDR_W         = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    input  logic              memwr,
    input  logic              memrd,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    output logic [31:0]       readData,
    output logic              rd_valid,
    output logic              busy,
    output logic              misalign
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t           state;
    logic [IDX_W-1:0] clr_cnt;
    logic [31:0]      mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             mis;
    logic [3:0]       be;
    logic [31:0]      lane_wd;
    logic [31:0]      rword;
    logic [31:0]      rshift;
    logic [31:0]      ld_val;
    logic [3:0]       mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      mem_wd;

    assign idx   = address[ADDR_W-1:2];
    assign rword = mem[idx];

    always_comb begin
        off = address[1:0];
        mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (size == 2'b01 && address[0]) || (size[1] && address[1:0] != 2'b00);
`else
        case (size)
            2'b00:   off = address[1:0];
            2'b01:   off = {address[1], 1'b0};
            default: off = 2'b00;
        endcase
`endif
    end

    always_comb begin
        case (size)
            2'b00: begin
                be      = 4'b0001 << off;
                lane_wd = {4{writedata[7:0]}};
            end
            2'b01: begin
                be      = off[1] ? 4'b1100 : 4'b0011;
                lane_wd = {2{writedata[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                lane_wd = writedata;
            end
        endcase
    end

    // Half accesses are always on an even offset here, so a shift by 0 or 16
    // brings the selected half down to bits 15:0.
    always_comb begin
        rshift = rword >> {off, 3'b000};
        case (size)
            2'b00:   ld_val = unsigned_ld ? {24'h0, rshift[7:0]}
                                          : {{24{rshift[7]}}, rshift[7:0]};
            2'b01:   ld_val = unsigned_ld ? {16'h0, rshift[15:0]}
                                          : {{16{rshift[15]}}, rshift[15:0]};
            default: ld_val = rword;
        endcase
    end

    // The sweep owns the write port while in ST_INIT; requests are dropped.
    always_comb begin
        mem_we  = 4'b0000;
        mem_idx = idx;
        mem_wd  = lane_wd;
        if (state == ST_INIT) begin
            mem_we  = 4'b1111;
            mem_idx = clr_cnt;
            mem_wd  = 32'h0;
        end else if (memwr && !mis) begin
            mem_we = be;
        end
    end

    // Array is deliberately not reset; the sweep provides defined contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we[i]) mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
            busy     <= (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;
            clr_cnt  <= '0;
            readData <= 32'h0;
            rd_valid <= 1'b0;
            misalign <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    rd_valid <= 1'b0;
                    misalign <= 1'b0;
                    clr_cnt  <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    rd_valid <= memrd;
                    misalign <= (memrd || memwr) && mis;
                    // Array read sees pre-edge contents: read-before-write.
                    if (memrd) readData <= mis ? 32'h0 : ld_val;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bytelane.sv
module tb_dmem_bytelane;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  address;
    logic [31:0] writedata;
    logic        memwr;
    logic        memrd;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] readData;
    logic        rd_valid;
    logic        busy;
    logic        misalign;

    int n_vec = 0;
    int n_err = 0;

    dmem_bytelane #(.ADDR_W(10), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .writedata(writedata),
        .memwr(memwr), .memrd(memrd), .size(size), .unsigned_ld(unsigned_ld),
        .readData(readData), .rd_valid(rd_valid), .busy(busy), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic        rd;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, logic wr, logic rd, logic [9:0] a,
                                logic [31:0] d, logic [1:0] s, logic u,
                                logic [31:0] e);
        vec_t v;
        v.name = n; v.wr = wr; v.rd = rd; v.addr = a; v.wd = d;
        v.sz = s; v.uns = u; v.exp = e;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(logic wr, logic rd, logic [9:0] a, logic [31:0] d,
                         logic [1:0] s, logic u);
        memwr = wr; memrd = rd; address = a; writedata = d;
        size = s; unsigned_ld = u;
    endtask

    task automatic clear_in();
        drive(1'b0, 1'b0, 10'h0, 32'h0, 2'b10, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops; also watches for any rd_valid leak.
    task automatic wait_sweep(output int n, output logic saw_rv);
        n = 0;
        saw_rv = 1'b0;
        do begin
            tick();
            n++;
            saw_rv |= rd_valid;
        end while (busy && n < 1000);
    endtask

    task automatic op(string name, logic wr, logic rd, logic [9:0] a,
                      logic [31:0] d, logic [1:0] s, logic u,
                      logic [31:0] exp, logic exp_mis);
        drive(wr, rd, a, d, s, u);
        tick();
        clear_in();
        check({name, ".data"}, readData, exp);
        check({name, ".valid"}, {31'h0, rd_valid}, {31'h0, rd});
        check({name, ".misalign"}, {31'h0, misalign}, {31'h0, exp_mis});
    endtask

    initial begin
        int   n;
        logic saw;

        rst_n = 1'b0;
        clear_in();

        tbl.push_back(mk("lw_3fc",       0, 1, 10'h3FC, 32'h0,        2'b10, 0, 32'h00000000));
        tbl.push_back(mk("lw_000_drop",  0, 1, 10'h000, 32'h0,        2'b10, 0, 32'h00000000));
        tbl.push_back(mk("sw_80",        1, 0, 10'h080, 32'hDEADBEEF, 2'b10, 0, 32'h00000000));
        tbl.push_back(mk("lw_80",        0, 1, 10'h080, 32'h0,        2'b10, 0, 32'hDEADBEEF));
        tbl.push_back(mk("lb_83",        0, 1, 10'h083, 32'h0,        2'b00, 0, 32'hFFFFFFDE));
        tbl.push_back(mk("lbu_83",       0, 1, 10'h083, 32'h0,        2'b00, 1, 32'h000000DE));
        tbl.push_back(mk("lh_80",        0, 1, 10'h080, 32'h0,        2'b01, 0, 32'hFFFFBEEF));
        tbl.push_back(mk("lhu_80",       0, 1, 10'h080, 32'h0,        2'b01, 1, 32'h0000BEEF));
        tbl.push_back(mk("lh_82",        0, 1, 10'h082, 32'h0,        2'b01, 0, 32'hFFFFDEAD));
        tbl.push_back(mk("lb_80",        0, 1, 10'h080, 32'h0,        2'b00, 0, 32'hFFFFFFEF));
        tbl.push_back(mk("lbu_81",       0, 1, 10'h081, 32'h0,        2'b00, 1, 32'h000000BE));
        tbl.push_back(mk("sb_82",        1, 0, 10'h082, 32'h00000055, 2'b00, 0, 32'h000000BE));
        tbl.push_back(mk("lw_80_sb",     0, 1, 10'h080, 32'h0,        2'b10, 0, 32'hDE55BEEF));
        tbl.push_back(mk("sh_84",        1, 0, 10'h084, 32'h00008001, 2'b01, 0, 32'hDE55BEEF));
        tbl.push_back(mk("lw_84",        0, 1, 10'h084, 32'h0,        2'b10, 0, 32'h00008001));
        tbl.push_back(mk("lh_84",        0, 1, 10'h084, 32'h0,        2'b01, 0, 32'hFFFF8001));
        tbl.push_back(mk("sh_86",        1, 0, 10'h086, 32'h00007FFF, 2'b01, 0, 32'hFFFF8001));
        tbl.push_back(mk("lw_84_sh",     0, 1, 10'h084, 32'h0,        2'b10, 0, 32'h7FFF8001));
        tbl.push_back(mk("lhu_86",       0, 1, 10'h086, 32'h0,        2'b01, 1, 32'h00007FFF));
        tbl.push_back(mk("sw_40",        1, 0, 10'h040, 32'h11111111, 2'b10, 0, 32'h00007FFF));
        tbl.push_back(mk("sw11_44",      1, 0, 10'h044, 32'h12345678, 2'b11, 0, 32'h00007FFF));
        tbl.push_back(mk("lw11_44",      0, 1, 10'h044, 32'h0,        2'b11, 0, 32'h12345678));
        tbl.push_back(mk("lb_44",        0, 1, 10'h044, 32'h0,        2'b00, 0, 32'h00000078));

        repeat (3) tick();
        check("rst.readData", readData, 32'h0);
        check("rst.rd_valid", {31'h0, rd_valid}, 32'h0);
        check("rst.busy",     {31'h0, busy}, 32'h1);
        check("rst.misalign", {31'h0, misalign}, 32'h0);

        // Requests held during the sweep must be dropped.
        drive(1'b1, 1'b1, 10'h000, 32'hA5A5A5A5, 2'b10, 1'b0);
        rst_n = 1'b1;
        wait_sweep(n, saw);
        clear_in();
        check("sweep.busy_cycles", n, 256);
        check("sweep.rd_valid_leak", {31'h0, saw}, 32'h0);
        check("sweep.busy_after", {31'h0, busy}, 32'h0);

        foreach (tbl[i])
            op(tbl[i].name, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd,
               tbl[i].sz, tbl[i].uns, tbl[i].exp, 1'b0);

        // Read-before-write on the same word.
        op("rbw", 1'b1, 1'b1, 10'h040, 32'h22222222, 2'b10, 1'b0, 32'h11111111, 1'b0);
        op("rbw_after", 1'b0, 1'b1, 10'h040, 32'h0, 2'b10, 1'b0, 32'h22222222, 1'b0);

        // Back-to-back loads with memrd held, then hold of readData.
        drive(1'b0, 1'b1, 10'h080, 32'h0, 2'b10, 1'b0);
        tick();
        check("b2b0.data", readData, 32'hDE55BEEF);
        check("b2b0.valid", {31'h0, rd_valid}, 32'h1);
        address = 10'h084;
        tick();
        check("b2b1.data", readData, 32'h7FFF8001);
        check("b2b1.valid", {31'h0, rd_valid}, 32'h1);
        clear_in();
        tick();
        check("hold.data", readData, 32'h7FFF8001);
        check("hold.valid", {31'h0, rd_valid}, 32'h0);

`ifdef DMEM_ALIGN_CHECK_EN
        op("lw_42_mis", 1'b0, 1'b1, 10'h042, 32'h0, 2'b10, 1'b0, 32'h00000000, 1'b1);
        op("sw_42_mis", 1'b1, 1'b0, 10'h042, 32'h33333333, 2'b10, 1'b0, 32'h00000000, 1'b1);
        op("lh_81_mis", 1'b0, 1'b1, 10'h081, 32'h0, 2'b01, 1'b0, 32'h00000000, 1'b1);
        op("lw_40_kept", 1'b0, 1'b1, 10'h040, 32'h0, 2'b10, 1'b0, 32'h22222222, 1'b0);
`else
        op("lw_42_algn", 1'b0, 1'b1, 10'h042, 32'h0, 2'b10, 1'b0, 32'h22222222, 1'b0);
        op("sw_42_algn", 1'b1, 1'b0, 10'h042, 32'h33333333, 2'b10, 1'b0, 32'h22222222, 1'b0);
        op("lh_81_algn", 1'b0, 1'b1, 10'h081, 32'h0, 2'b01, 1'b0, 32'hFFFFBEEF, 1'b0);
        op("lw_40_new", 1'b0, 1'b1, 10'h040, 32'h0, 2'b10, 1'b0, 32'h33333333, 1'b0);
`endif

        // Reset in the middle of a sweep restarts it from word 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (100) tick();
        check("mid.busy_before", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid.busy_rst", {31'h0, busy}, 32'h1);
        tick();
        rst_n = 1'b1;
        wait_sweep(n, saw);
        check("mid.busy_cycles", n, 256);
        op("lw_80_cleared", 1'b0, 1'b1, 10'h080, 32'h0, 2'b10, 1'b0, 32'h00000000, 1'b0);

        // Reset zeroes readData: load a nonzero value first, then reset.
        op("pre_rst_ld", 1'b0, 1'b1, 10'h000, 32'h0, 2'b10, 1'b0, 32'h00000000, 1'b0);
        op("pre_rst_sw", 1'b1, 1'b0, 10'h3FC, 32'hCAFEF00D, 2'b10, 1'b0, 32'h00000000, 1'b0);
        op("pre_rst_lw", 1'b0, 1'b1, 10'h3FC, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst2.readData", readData, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
